// File: rtl/led_to_bcd_capture.sv
// led_to_bcd_capture
// Reads back the multiplexed, active-low 4-digit 7-segment display lines.
// Each digit is debounced and decoded to a hex nibble. Once all four digits
// have been captured, the complete 16-bit frame is offered over valid/ready.
//
// Build option: define LED_CAPTURE_ERR_EN to capture illegal glyphs as
// nibble 0 with a per-digit error flag. When it is undefined, illegal glyphs
// are dropped, and digit_err is constant 0.
//
// Ports:
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   seg_in[6:0]  active-low segments {g,f,e,d,c,b,a}
//   an_in[3:0]   active-low anodes, bit i = digit i (digit 0 = LS nibble)
//   bcd_out      captured frame, digit i in [4i+3:4i]
//   digit_err    per-digit illegal-glyph flag of the captured frame
//   frame_valid  bcd_out/digit_err hold an unconsumed frame
//   frame_ready  consumer accepts the frame
//   overrun      sticky: an unconsumed frame was overwritten
module led_to_bcd_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] bcd_out,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {WAIT, ACCEPT, HOLD} state_t;

  state_t          state, state_nxt;
  logic [3:0]      smp_an;
  logic [6:0]      smp_seg;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            changed;
  logic [3:0]      wr_mask;
  logic [3:0]      seen;
  logic [3:0][3:0] slot_nib;
  logic [4:0]      dec;      // {illegal, nibble}
  logic            wr_ok;
  logic            complete;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b0000011: decode = 5'h0B;
      7'b1000110: decode = 5'h0C;
      7'b0100001: decode = 5'h0D;
      7'b0000110: decode = 5'h0E;
      7'b0001110: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  assign changed  = {an_in, seg_in} != {smp_an, smp_seg};
  assign dec      = decode(smp_seg);
  assign complete = (seen == 4'b1111);

`ifdef LED_CAPTURE_ERR_EN
  logic [3:0] slot_err;
  assign wr_ok = 1'b1;
`else
  assign wr_ok     = ~dec[4];
  assign digit_err = 4'b0000;
`endif

  // Stability counter: counts consecutive identical samples, saturating at
  // STABLE_CYCLES so the compare below stays exact.
  always_comb begin
    cnt_nxt = cnt;
    if (changed)              cnt_nxt = CW'(1);
    else if (cnt != CNT_MAX)  cnt_nxt = cnt + CW'(1);
  end

  // The shared sample stream is debounced once; the anode field of the
  // accepted sample decides which digit the accept belongs to.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT:    if (cnt_nxt == CNT_MAX) state_nxt = ACCEPT;
      ACCEPT:  state_nxt = changed ? WAIT : HOLD;
      HOLD:    if (changed) state_nxt = WAIT;
      default: state_nxt = WAIT;
    endcase
  end

  // Blanking (1111) and multi-low anodes are not one-hot, so nothing is written.
  always_comb begin
    wr_mask = 4'b0000;
    if (state == ACCEPT && $onehot(~smp_an) && wr_ok) wr_mask = ~smp_an;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= WAIT;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp_an      <= 4'b1111;
      smp_seg     <= 7'b1111111;
      cnt         <= '0;
      seen        <= 4'b0000;
      slot_nib    <= '0;
      bcd_out     <= 16'h0000;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
`ifdef LED_CAPTURE_ERR_EN
      slot_err    <= 4'b0000;
      digit_err   <= 4'b0000;
`endif
    end else begin
      smp_an  <= an_in;
      smp_seg <= seg_in;
      cnt     <= cnt_nxt;
      // Completion clears seen; a same-edge accept can still start the next one.
      seen    <= (complete ? 4'b0000 : seen) | wr_mask;
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) begin
          slot_nib[i] <= dec[3:0];
`ifdef LED_CAPTURE_ERR_EN
          slot_err[i] <= dec[4];
`endif
        end
      end
      if (complete) begin
        bcd_out     <= slot_nib;
`ifdef LED_CAPTURE_ERR_EN
        digit_err   <= slot_err;
`endif
        frame_valid <= 1'b1;
        if (frame_valid && !frame_ready) overrun <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_to_bcd_capture.sv
module tb_led_to_bcd_capture;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  int vld_cycles = 0;
  int base;
  logic [15:0] last_bcd = '0;
  logic [3:0]  last_err = '0;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                         G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011,
                         GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110,
                         GF = 7'b0001110, GX = 7'b1111111;

  led_to_bcd_capture #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
    .bcd_out(bcd_out), .digit_err(digit_err), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every cycle a frame is presented, and its contents.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      vld_cycles = vld_cycles + 1;
      last_bcd   = bcd_out;
      last_err   = digit_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] d0, input logic [6:0] d1,
                      input logic [6:0] d2, input logic [6:0] d3);
    show(4'b1110, d0, 6);
    show(4'b1101, d1, 6);
    show(4'b1011, d2, 6);
    show(4'b0111, d3, 6);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; frame_ready = 1'b1; an_in = 4'b1111; seg_in = GX;
    repeat (2) @(negedge clk);
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_err", 32'(digit_err), 32'h0);
    check("rst_valid", 32'(frame_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;

    // Basic scan
    base = vld_cycles;
    scan(G3, G8, G1, GF);
    check("basic_vld_cycles", 32'(vld_cycles - base), 32'd1);
    check("basic_bcd", 32'(last_bcd), 32'hF183);
    check("basic_overrun", 32'(overrun), 32'h0);
    check("basic_valid_drop", 32'(frame_valid), 32'h0);

    // Glitch on digit 0 must not be captured
    base = vld_cycles;
    show(4'b1110, G2, 2);
    show(4'b1110, G1, 6);
    show(4'b1101, G8, 6);
    show(4'b1011, G1, 6);
    show(4'b0111, GF, 6);
    repeat (2) @(negedge clk);
    check("glitch_vld_cycles", 32'(vld_cycles - base), 32'd1);
    check("glitch_bcd", 32'(last_bcd), 32'hF181);

    // Back-pressure: two frames while not ready
    frame_ready = 1'b0;
    scan(G4, G3, G2, G1);
    check("bp1_valid", 32'(frame_valid), 32'h1);
    check("bp1_bcd", 32'(bcd_out), 32'h1234);
    check("bp1_overrun", 32'(overrun), 32'h0);
    scan(G8, G7, G6, G5);
    check("bp2_valid", 32'(frame_valid), 32'h1);
    check("bp2_bcd", 32'(bcd_out), 32'h5678);
    check("bp2_overrun", 32'(overrun), 32'h1);
    frame_ready = 1'b1;
    @(negedge clk);
    check("bp_consume", 32'(frame_valid), 32'h0);

    // Illegal glyph on digit 2
    base = vld_cycles;
    scan(G0, GA, GX, GC);
`ifdef LED_CAPTURE_ERR_EN
    check("illegal_vld_cycles", 32'(vld_cycles - base), 32'd1);
    check("illegal_bcd", 32'(last_bcd), 32'hC0A0);
    check("illegal_err", 32'(last_err), 32'h4);
    show(4'b1011, GD, 6);
    repeat (2) @(negedge clk);
    check("illegal_no_extra", 32'(vld_cycles - base), 32'd1);
`else
    check("illegal_no_frame", 32'(vld_cycles - base), 32'd0);
    show(4'b1011, GD, 6);
    repeat (2) @(negedge clk);
    check("illegal_fixed_vld", 32'(vld_cycles - base), 32'd1);
    check("illegal_fixed_bcd", 32'(last_bcd), 32'hCDA0);
    check("illegal_fixed_err", 32'(last_err), 32'h0);
`endif

    // Blanking and multi-low anodes ignored
    base = vld_cycles;
    show(4'b1110, G9, 6);
    show(4'b1111, G8, 6);
    show(4'b1101, GE, 6);
    show(4'b1100, G0, 6);
    show(4'b1011, GB, 6);
    show(4'b0111, G7, 6);
    repeat (2) @(negedge clk);
    check("blank_vld_cycles", 32'(vld_cycles - base), 32'd1);
    check("blank_bcd", 32'(last_bcd), 32'h7BE9);
    check("blank_err", 32'(last_err), 32'h0);

    // Reset mid-frame
    show(4'b1110, G1, 6);
    show(4'b1101, G2, 6);
    show(4'b1011, G3, 6);
    an_in = 4'b1111; seg_in = GX; rst_n = 1'b0;
    @(negedge clk);
    check("midrst_bcd", 32'(bcd_out), 32'h0);
    check("midrst_err", 32'(digit_err), 32'h0);
    check("midrst_valid", 32'(frame_valid), 32'h0);
    check("midrst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    base = vld_cycles;
    show(4'b0111, G7, 6);
    repeat (2) @(negedge clk);
    check("midrst_no_frame", 32'(vld_cycles - base), 32'd0);
    show(4'b1110, G4, 6);
    show(4'b1101, G5, 6);
    show(4'b1011, G6, 6);
    repeat (2) @(negedge clk);
    check("midrst_vld_cycles", 32'(vld_cycles - base), 32'd1);
    check("midrst_bcd", 32'(last_bcd), 32'h7654);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
